axis_byte_packer: RTL

// - Upstream of the processor's s_axis input. Packs an 8-bit AXI-Stream byte stream
//   (e.g. from a UART receiver) into WORD_WIDTH-bit words.
// - The first byte received fills the most-significant byte of each word.
// - An optional idle timeout discards a stale partial word, so a lost byte cannot

---
 rtl/axis_byte_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/axis_byte_packer.sv
// Packs an 8-bit AXI-Stream byte stream into WORD_WIDTH-bit words, first byte in the MSBs.
// An optional idle timeout discards a stale partial word so one lost byte cannot
// misalign every following word.
module axis_byte_packer #(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [WORD_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  drop
);

  localparam int unsigned NB     = WORD_WIDTH / 8;
  localparam int unsigned CNT_W  = $clog2(NB + 1);
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                state_q,    state_d;
  logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0]     idle_cnt_q, idle_cnt_d;
  logic [WORD_WIDTH-1:0] shift_q,    shift_d;
  logic [WORD_WIDTH-1:0] tdata_q,    tdata_d;
  logic                  tvalid_q,   tvalid_d;
  logic                  drop_q,     drop_d;

  logic                  byte_acc;
  logic                  word_hs;
  logic                  last_byte;
  logic [WORD_WIDTH-1:0] shift_in;

  // In HOLD the input is only open when the held word leaves in the same cycle.
  assign s_axis_tready = (state_q == FILL) ? 1'b1 : m_axis_tready;
  assign byte_acc      = s_axis_tvalid && s_axis_tready;
  assign word_hs       = tvalid_q && m_axis_tready;
  assign last_byte     = (byte_cnt_q == CNT_W'(NB - 1));
  // Older bytes shift toward the MSBs; truncation also covers the single-byte word.
  assign shift_in      = WORD_WIDTH'({shift_q, s_axis_tdata});

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop          = drop_q;

  // Next-state, byte accumulation and idle-timeout decisions.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    idle_cnt_d = idle_cnt_q;
    shift_d    = shift_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    drop_d     = 1'b0;

    case (state_q)
      FILL: begin
        if (byte_acc) begin
          shift_d    = shift_in;
          idle_cnt_d = '0;
          if (last_byte) begin
            tdata_d    = shift_in;
            tvalid_d   = 1'b1;
            byte_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end else if (byte_cnt_q == '0) begin
          idle_cnt_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          // This idle cycle brings the count to TIMEOUT_CYCLES: discard the partial word.
          if (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            byte_cnt_d = '0;
            idle_cnt_d = '0;
            drop_d     = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end

      HOLD: begin
        if (word_hs) begin
          tvalid_d = 1'b0;
          state_d  = FILL;
          if (byte_acc) begin
            shift_d = shift_in;
            if (NB == 1) begin
              tdata_d  = shift_in;
              tvalid_d = 1'b1;
              state_d  = HOLD;
            end else begin
              byte_cnt_d = CNT_W'(1);
            end
          end
        end
      end

      default: state_d = FILL;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      idle_cnt_q <= '0;
      shift_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      shift_q    <= shift_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      drop_q     <= drop_d;
    end
  end

endmodule
